// File: rtl/cache_set_engine.sv
// Set-associative cache tag/state engine: per-line valid/dirty, LRU/FIFO ranks,
// write-back-allocate or write-through-no-allocate, victim reporting, saturating stats.
module cache_set_engine #(
  parameter int ADDR_W    = 48,
  parameter int BLOCKSIZE = 64,
  parameter int CACHESIZE = 2048,
  parameter int ASSOC     = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic              replace_policy,
  input  logic              write_policy,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_evict,
  output logic [ADDR_W-1:0] evict_addr,
  output logic              evict_dirty,
  output logic [CNT_W-1:0]  reads,
  output logic [CNT_W-1:0]  writes,
  output logic [CNT_W-1:0]  read_misses,
  output logic [CNT_W-1:0]  write_misses,
  output logic [CNT_W-1:0]  writebacks,
  output logic [CNT_W-1:0]  wt_writes
);
  localparam int NUMSETS  = CACHESIZE / (BLOCKSIZE * ASSOC);
  localparam int OFFSET_W = $clog2(BLOCKSIZE);
  localparam int INDEX_W  = $clog2(NUMSETS);
  localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
  localparam int IW       = (INDEX_W > 0) ? INDEX_W : 1;
  localparam int RANK_W   = $clog2(ASSOC);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;
  state_t state_q, state_d;

  logic [NUMSETS-1:0][ASSOC-1:0]             valid_q, dirty_q;
  logic [NUMSETS-1:0][ASSOC-1:0][TAG_W-1:0]  tag_q;
  logic [NUMSETS-1:0][ASSOC-1:0][RANK_W-1:0] rank_q;

  logic [TAG_W-1:0]  req_tag, tag_r;
  logic [IW-1:0]     req_idx, idx_r;
  logic              we_r, lru_r, wb_r;
  logic              hit_q;
  logic [RANK_W-1:0] hit_way_q, vic_way_q;

  // Offset bits only select a byte within the line.
  wire unused_offset = ^req_addr[OFFSET_W-1:0];

  assign req_tag = req_addr[OFFSET_W+INDEX_W +: TAG_W];
  generate
    if (INDEX_W > 0) begin : g_idx
      assign req_idx = req_addr[OFFSET_W +: IW];
    end else begin : g_noidx
      assign req_idx = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tag_r <= '0; idx_r <= '0; we_r <= 1'b0; lru_r <= 1'b0; wb_r <= 1'b0;
    end else if (req_valid && req_ready) begin
      tag_r <= req_tag; idx_r <= req_idx; we_r <= req_we;
      lru_r <= replace_policy; wb_r <= write_policy;
    end

  // Tag match per way; victim is the lowest invalid way, else the oldest rank.
  logic [ASSOC-1:0]  match;
  logic              lk_hit, any_inv;
  logic [RANK_W-1:0] lk_hit_way, inv_way, old_way;

  for (genvar w = 0; w < ASSOC; w++) begin : g_way
    assign match[w] = valid_q[idx_r][w] && (tag_q[idx_r][w] == tag_r);
  end

  always_comb begin
    lk_hit     = |match;
    lk_hit_way = '0;
    old_way    = '0;
    inv_way    = '0;
    any_inv    = 1'b0;
    for (int w = 0; w < ASSOC; w++) begin
      if (match[w]) lk_hit_way = RANK_W'(w);
      if (rank_q[idx_r][w] == RANK_W'(ASSOC - 1)) old_way = RANK_W'(w);
    end
    for (int w = ASSOC - 1; w >= 0; w--)
      if (!valid_q[idx_r][w]) begin
        inv_way = RANK_W'(w);
        any_inv = 1'b1;
      end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hit_q <= 1'b0; hit_way_q <= '0; vic_way_q <= '0;
    end else if (state_q == LOOKUP) begin
      hit_q     <= lk_hit;
      hit_way_q <= lk_hit_way;
      vic_way_q <= any_inv ? inv_way : old_way;
    end

  logic              fill, touch, evict, vic_v, vic_d;
  logic [RANK_W-1:0] t_way, t_rank;
  logic [TAG_W-1:0]  vic_tag;
  logic [ADDR_W-1:0] vic_addr;

  assign fill     = !hit_q && (!we_r || wb_r);
  assign touch    = (hit_q && lru_r) || fill;
  assign t_way    = hit_q ? hit_way_q : vic_way_q;
  assign t_rank   = rank_q[idx_r][t_way];
  assign vic_v    = valid_q[idx_r][vic_way_q];
  assign vic_d    = dirty_q[idx_r][vic_way_q];
  assign vic_tag  = tag_q[idx_r][vic_way_q];
  assign evict    = fill && vic_v;
  assign vic_addr = (ADDR_W'(vic_tag) << (OFFSET_W + INDEX_W)) | (ADDR_W'(idx_r) << OFFSET_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= '0; dirty_q <= '0; tag_q <= '0;
      for (int s = 0; s < NUMSETS; s++)
        for (int w = 0; w < ASSOC; w++) rank_q[s][w] <= RANK_W'(w);
      reads <= '0; writes <= '0; read_misses <= '0;
      write_misses <= '0; writebacks <= '0; wt_writes <= '0;
      resp_hit <= 1'b0; resp_evict <= 1'b0; evict_addr <= '0; evict_dirty <= 1'b0;
    end else if (state_q == UPDATE) begin
      // Touched way becomes MRU; only younger ranks age, keeping a permutation.
      if (touch)
        for (int w = 0; w < ASSOC; w++)
          if (RANK_W'(w) == t_way)           rank_q[idx_r][w] <= '0;
          else if (rank_q[idx_r][w] < t_rank) rank_q[idx_r][w] <= rank_q[idx_r][w] + 1'b1;
      if (fill) begin
        valid_q[idx_r][vic_way_q] <= 1'b1;
        tag_q[idx_r][vic_way_q]   <= tag_r;
        dirty_q[idx_r][vic_way_q] <= we_r;
      end else if (hit_q && we_r && wb_r) begin
        dirty_q[idx_r][hit_way_q] <= 1'b1;
      end
      reads        <= sat_inc(reads, !we_r);
      writes       <= sat_inc(writes, we_r);
      read_misses  <= sat_inc(read_misses, !we_r && !hit_q);
      write_misses <= sat_inc(write_misses, we_r && !hit_q);
      writebacks   <= sat_inc(writebacks, evict && vic_d);
      wt_writes    <= sat_inc(wt_writes, we_r && !wb_r);
      resp_hit     <= hit_q;
      resp_evict   <= evict;
      evict_addr   <= evict ? vic_addr : '0;
      evict_dirty  <= evict && vic_d;
    end
endmodule

// File: doc/cache_set_engine.md
Name: cache_set_engine

Overview:
- Parametrised single-level, set-associative cache tag/state engine; next generation of the two-level cache engine.
- Adds a valid/dirty bit per line, a valid/ready request handshake and per-request LRU or FIFO replacement.
- Supports write-back-allocate or write-through-no-allocate, reports victim evictions, and keeps saturating statistics counters.
- Instantiated once per cache level; the L1 eviction output feeds the L2 instance's request port.

Parameters:
- ADDR_W, 48, request address width.
- BLOCKSIZE, 64, bytes per line (power of 2); OFFSET_W = log2(BLOCKSIZE).
- CACHESIZE, 2048, total bytes (power of 2).
- ASSOC, 8, ways per set (power of 2, >=2).
- NUMSETS, CACHESIZE/(BLOCKSIZE*ASSOC), derived; INDEX_W = log2(NUMSETS), 0 allowed; TAG_W = ADDR_W-OFFSET_W-INDEX_W.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_we  in  1  1=write, 0=read.
- replace_policy  in  1  0=FIFO, 1=LRU; sampled at accept.
- write_policy  in  1  0=write-through no-allocate, 1=write-back allocate; sampled at accept.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  request hit.
- resp_evict  out  1  a valid line was replaced.
- evict_addr  out  ADDR_W  {victim tag, index, OFFSET_W'0}.
- evict_dirty  out  1  victim was dirty.
- reads, writes, read_misses, write_misses, writebacks, wt_writes  out  CNT_W each  statistics.

Behaviour:
- Reset:
  - All lines invalid and clean; way i rank = i (rank 0 = MRU/newest).
  - All counters 0; state IDLE; req_ready=1.
  - resp_valid, resp_hit, resp_evict, evict_dirty = 0; evict_addr = 0.
- FSM IDLE -> LOOKUP -> UPDATE -> RESP -> IDLE:
  - IDLE: accept when req_valid && req_ready. Latch addr, we and both policies; split into tag/index.
  - LOOKUP: compare the latched tag against all valid ways of the set. Record hit way, or pick the victim: lowest-index invalid way, else the way with rank ASSOC-1.
  - UPDATE: apply line, rank and counter updates.
  - RESP: resp_valid=1 for exactly this cycle, with resp_hit/resp_evict/evict_* valid. Response outputs hold their values until the next RESP.
- Latency: resp_valid is asserted 3 cycles after the accept edge. Throughput is one request per 4 cycles. req_ready=0 in LOOKUP, UPDATE and RESP.
- Counters:
  - reads +1 per accepted read; writes +1 per accepted write.
  - read_misses / write_misses +1 on the corresponding miss.
  - All counters saturate at all-ones and never wrap.
- Rank update, when way w of rank r becomes MRU: ranks < r increment, w gets rank 0, other ranks unchanged. Ranks always form a permutation of 0..ASSOC-1 per set.
- Read hit: LRU applies the rank update; FIFO leaves ranks unchanged.
- Read miss:
  - Fill victim: valid=1, dirty=0, tag written; apply the rank update (both policies).
  - If the victim was valid: resp_evict=1, evict_addr/evict_dirty taken from the victim.
  - writebacks +1 if the victim was dirty.
- Write, write_policy=1:
  - Hit: dirty=1; ranks as for a read hit.
  - Miss: allocate as for a read miss, then dirty=1.
- Write, write_policy=0:
  - wt_writes +1 on every write.
  - Hit: line stays clean (an existing dirty bit is retained); ranks as for a read hit.
  - Miss: no allocation, no rank change, resp_evict=0.
- A policy change between requests is legal; existing rank/dirty state is reused as-is.
- reset asserted mid-transaction aborts it: no resp_valid, all state cleared immediately, req_ready=1 on the first clk edge after deassertion.
- Address bits above TAG_W+INDEX_W+OFFSET_W do not exist; the offset is ignored for lookup.

Test Plan:
- Defaults (4 sets, index = addr[7:6]). After reset, read 0x1000 then read 0x1000 -> first resp_hit=0/resp_evict=0, second resp_hit=1; reads=2, read_misses=1. resp_valid exactly 3 cycles after each accept.
- LRU: read 0x000,0x100,...,0x700, then 0x000 (hit), then 0x800 -> miss, resp_evict=1, evict_addr=0x100, evict_dirty=0.
- FIFO: same sequence -> 0x000 hits, but 0x800 evicts evict_addr=0x000.
- Write-back: write 0x040 (miss, allocate), read 0x140..0x740 (LRU), then read 0x840 -> evict_addr=0x040, evict_dirty=1, writebacks=1, write_misses=1.
- Write-through: write 0x2000 -> resp_hit=0, write_misses=1, wt_writes=1; next read 0x2000 -> miss, resp_evict=0.
- Reset asserted during LOOKUP after a hit to 0x1000 was cached -> no resp_valid, all counters 0. After deassertion, read 0x1000 misses. With CNT_W=4, 17 reads leave reads=15.
